// File: rtl/sha256_stream_core.sv
// sha256_stream_core: multi-block SHA-256 engine, one compression round per clock.
// Padded 512-bit blocks arrive as a valid/ready beat stream. DATA_W is 32 or 64. A 64-bit beat
// carries two message words, most-significant word first. The hash chains across blocks unless
// in_first requests a fresh IV.
// Ports:
//   clk, rst                         rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready               beat handshake
//   in_data, in_first                message beat; in_first is sampled on beat 0 (1 = load IV)
//   busy                             high while compressing (ROUND or UPDATE)
//   done                             one-cycle pulse after each block's H update
//   digest_vld                       H0..H7 hold the result of the last completed block
//   rd_addr, rd_data                 combinational readout of H[rd_addr]
// Optional build macro SHA224_EN adds input `mode`, which is sampled on beat 0 when
// in_first = 1. When mode = 1 the block starts from the SHA-224 IV and H7 reads as zero.
module sha256_stream_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
`ifdef SHA224_EN
    input  logic              mode,
`endif
    output logic              busy,
    output logic              done,
    output logic              digest_vld,
    input  logic [2:0]        rd_addr,
    output logic [31:0]       rd_data
);

    localparam int WordsPerBeat = DATA_W / 32;
    localparam int BeatsPerBlk  = 16 / WordsPerBeat;
    localparam logic [3:0] LastBeat = 4'(BeatsPerBlk - 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
`ifdef SHA224_EN
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    typedef enum logic [1:0] {StLoad, StRound, StUpdate} state_t;
    state_t state_q, state_d;

    logic [3:0]  beat_q;
    logic [5:0]  round_q;
    logic        first_q;
    logic [31:0] h_q [8];    // chained hash H0..H7
    logic [31:0] v_q [8];    // working variables a..h
    logic [31:0] w_q [16];   // rolling schedule window, w_q[0] = W[t]
    logic [31:0] base [8];
    logic [31:0] t1, t2, w_new;
    logic        accept;
`ifdef SHA224_EN
    logic        mode_q;
`endif

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction
    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction
    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction
    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StLoad;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid && beat_q == LastBeat) state_d = StRound;
            end
            StRound: begin
                busy = 1'b1;
                if (round_q == 6'd63) state_d = StUpdate;
            end
            StUpdate: begin
                busy    = 1'b1;
                state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Feed-forward base: the IV for a fresh message, otherwise the chained H.
    // H only changes in UPDATE, so it can serve as the base without a copy.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef SHA224_EN
            base[i] = first_q ? (mode_q ? IV224[i] : IV256[i]) : h_q[i];
`else
            base[i] = first_q ? IV256[i] : h_q[i];
`endif
        end
    end

    always_comb begin
        t1 = v_q[7] + big_s1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
           + K[round_q] + w_q[0];
        t2 = big_s0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q     <= 4'd0;
            round_q    <= 6'd0;
            first_q    <= 1'b0;
            done       <= 1'b0;
            digest_vld <= 1'b0;
`ifdef SHA224_EN
            mode_q     <= 1'b0;
`endif
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= IV256[i];
                v_q[i] <= 32'd0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                beat_q <= (beat_q == LastBeat) ? 4'd0 : beat_q + 4'd1;
                for (int i = 0; i < 16 - WordsPerBeat; i++) w_q[i] <= w_q[i + WordsPerBeat];
                for (int j = 0; j < WordsPerBeat; j++) begin
                    w_q[16 - WordsPerBeat + j] <= in_data[DATA_W - 1 - 32 * j -: 32];
                end
                if (beat_q == 4'd0) begin
                    first_q    <= in_first;
                    digest_vld <= 1'b0;
`ifdef SHA224_EN
                    if (in_first) mode_q <= mode;
`endif
                end
                if (beat_q == LastBeat) begin
                    for (int i = 0; i < 8; i++) v_q[i] <= base[i];
                    round_q <= 6'd0;
                end
            end
            if (state_q == StRound) begin
                v_q[0] <= t1 + t2;
                v_q[1] <= v_q[0];
                v_q[2] <= v_q[1];
                v_q[3] <= v_q[2];
                v_q[4] <= v_q[3] + t1;
                v_q[5] <= v_q[4];
                v_q[6] <= v_q[5];
                v_q[7] <= v_q[6];
                for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
                w_q[15] <= w_new;
                round_q <= round_q + 6'd1;
            end
            if (state_q == StUpdate) begin
                for (int i = 0; i < 8; i++) h_q[i] <= base[i] + v_q[i];
                done       <= 1'b1;
                digest_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = h_q[rd_addr];
`ifdef SHA224_EN
        if (mode_q && rd_addr == 3'd7) rd_data = 32'h0;
`endif
    end

endmodule
